// File: rtl/key_pulse.sv
// key_pulse: debounces a raw push-button and emits one registered clock pulse
// per confirmed press, plus a registered debounced key level.
// A press or release is accepted only after the synchronized key holds its new
// level for 2^N consecutive cycles inside the corresponding check state.
module key_pulse #(
    parameter int   N       = 20,
    parameter logic KEY_ACT = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic key_in,
    output logic dout,
    output logic level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PCHK = 2'd1,
        S_HELD = 2'd2,
        S_RCHK = 2'd3
    } state_t;

    // Synchronizer: polarity is normalized on entry so sync2 = 1 always means pressed.
    logic         sync1_d;
    logic         sync1_q;
    logic         sync2_q;

    state_t       state_d;
    state_t       state_q;
    logic [N-1:0] cnt_d;
    logic [N-1:0] cnt_q;
    logic         dout_d;
    logic         dout_q;
    logic         level_d;
    logic         level_q;

    assign sync1_d = key_in ^ ~KEY_ACT;

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next-state, stability counter and registered output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sync2_q) begin
                    state_d = S_PCHK;
                    cnt_d   = '1;
                end
            end
            S_PCHK: begin
                // A bounce back to inactive wins over an expiring counter.
                if (!sync2_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_HELD;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - N'(1);
                end
            end
            S_HELD: begin
                if (!sync2_q) begin
                    state_d = S_RCHK;
                    cnt_d   = '1;
                end
            end
            S_RCHK: begin
                // Returning to active cancels the release without a new pulse.
                if (sync2_q) begin
                    state_d = S_HELD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - N'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        level_d = (state_d == S_HELD) || (state_d == S_RCHK);
    end

    // State, counter and output registers; reset forces everything idle at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            level_q <= level_d;
        end
    end

    assign dout  = dout_q;
    assign level = level_q;

endmodule

// File: tb/tb_key_pulse.sv
// Bench for key_pulse with N = 2. Two instances run side by side: one active-high
// and one active-low fed with the inverted key, so both must behave identically.
// The reference model describes debouncing as run lengths: a level change is
// accepted once the synchronized key has shown the new level on 2^N + 1
// consecutive clock samples.
module tb_key_pulse;

    localparam int N    = 2;
    localparam int HOLD = (1 << N) + 1;

    logic clk    = 1'b0;
    logic n_rst  = 1'b0;
    logic key_in = 1'b0;
    logic key_n;
    logic dout_h;
    logic level_h;
    logic dout_l;
    logic level_l;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_s1;
    bit m_s2;
    bit m_level;
    bit m_pulse;
    int m_run;

    assign key_n = ~key_in;

    key_pulse #(.N(N), .KEY_ACT(1'b1)) dut_h (
        .clk   (clk),
        .n_rst (n_rst),
        .key_in(key_in),
        .dout  (dout_h),
        .level (level_h)
    );

    key_pulse #(.N(N), .KEY_ACT(1'b0)) dut_l (
        .clk   (clk),
        .n_rst (n_rst),
        .key_in(key_n),
        .dout  (dout_l),
        .level (level_l)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_run   = 0;
    endtask

    // Advance one rising edge, update the model, then settle 1 ns past the edge.
    task automatic step();
        bit seen;
        @(posedge clk);
        if (!n_rst) begin
            model_clear();
        end else begin
            seen    = m_s2;
            m_pulse = 1'b0;
            if (!m_level) begin
                m_run = seen ? m_run + 1 : 0;
                if (m_run == HOLD) begin
                    m_level = 1'b1;
                    m_pulse = 1'b1;
                    m_run   = 0;
                end
            end else begin
                m_run = !seen ? m_run + 1 : 0;
                if (m_run == HOLD) begin
                    m_level = 1'b0;
                    m_run   = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
        #1;
    endtask

    // Reset both instances with the key released; returns at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        n_rst  = 1'b0;
        key_in = 1'b0;
        model_clear();
        repeat (2) begin
            step();
            @(negedge clk);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        key_in = 1'b1;
        repeat (3) begin
            step();
            @(negedge clk);
        end
        checks++;
        if (dout_h !== 1'b0 || level_h !== 1'b0 || dout_l !== 1'b0 || level_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dout=%b/%b level=%b/%b expected all 0", dout_h, dout_l, level_h, level_l);
        end
        do_reset();
        for (int e = 0; e < 10; e++) begin
            key_in = 1'b0;
            step();
            checks++;
            if (dout_h !== 1'b0 || level_h !== 1'b0 || dout_l !== 1'b0 || level_l !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle e=%0d dout=%b/%b level=%b/%b expected all 0", e, dout_h, dout_l, level_h, level_l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        for (int e = 0; e < 56; e++) begin
            key_in = 1'b1;
            step();
            checks++;
            if (dout_h !== (e == 6) || level_h !== (e >= 6)) begin
                errors++;
                $display("FAIL clean_press e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 6), (e >= 6));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int e = 0; e < 30; e++) begin
            key_in = (e < 3) ? 1'b1 : (e == 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (dout_h !== (e == 10) || level_h !== (e >= 10)) begin
                errors++;
                $display("FAIL bounce e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 10), (e >= 10));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_release_glitch();
        do_reset();
        for (int e = 0; e < 42; e++) begin
            key_in = (e < 11) ? 1'b1 : (e < 13) ? 1'b0 : (e < 26) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (dout_h !== (e == 6) || level_h !== (e >= 6 && e < 32)) begin
                errors++;
                $display("FAIL release e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 6), (e >= 6 && e < 32));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        // Press and reach S_PCHK with the counter at 2, then reset asynchronously.
        for (int e = 0; e < 4; e++) begin
            key_in = 1'b1;
            step();
            if (e < 3) @(negedge clk);
        end
        #1;
        n_rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dout_h !== 1'b0 || level_h !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_check dout=%b level=%b expected 0 0", dout_h, level_h);
        end
        @(negedge clk);
        step();
        @(negedge clk);
        n_rst = 1'b1;
        // Key still held: must be treated as a fresh press; reset again during the pulse.
        for (int e = 0; e < 7; e++) begin
            key_in = 1'b1;
            step();
            checks++;
            if (dout_h !== (e == 6) || level_h !== (e >= 6)) begin
                errors++;
                $display("FAIL reset_fresh_press e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 6), (e >= 6));
            end
            if (e < 6) @(negedge clk);
        end
        #1;
        n_rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dout_h !== 1'b0 || level_h !== 1'b0 || dout_l !== 1'b0 || level_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse dout=%b/%b level=%b/%b expected all 0", dout_h, dout_l, level_h, level_l);
        end
        @(negedge clk);
        step();
        @(negedge clk);
        n_rst = 1'b1;
        for (int e = 0; e < 12; e++) begin
            key_in = 1'b1;
            step();
            checks++;
            if (dout_h !== (e == 6) || level_h !== (e >= 6)) begin
                errors++;
                $display("FAIL reset_second_press e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 6), (e >= 6));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_active_low();
        do_reset();
        // key_n (the active-low instance's pin) falls 1 -> 0 and stays low.
        for (int e = 0; e < 20; e++) begin
            key_in = 1'b1;
            step();
            checks++;
            if (dout_l !== (e == 6) || level_l !== (e >= 6)) begin
                errors++;
                $display("FAIL active_low e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_l, level_l, (e == 6), (e >= 6));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        // Key drops exactly when the press counter reaches zero: rejected.
        for (int e = 0; e < 20; e++) begin
            key_in = (e < 4) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (dout_h !== 1'b0 || level_h !== 1'b0) begin
                errors++;
                $display("FAIL boundary_reject e=%0d dout=%b level=%b expected 0 0", e, dout_h, level_h);
            end
            @(negedge clk);
        end
        // One more active sample is enough for a press, followed by a clean release.
        for (int e = 0; e < 20; e++) begin
            key_in = (e < 5) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (dout_h !== (e == 6) || level_h !== (e >= 6 && e < 11)) begin
                errors++;
                $display("FAIL boundary_accept e=%0d dout=%b level=%b expected dout=%b level=%b", e, dout_h, level_h, (e == 6), (e >= 6 && e < 11));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int seg = 0;
        bit v   = 1'b0;
        do_reset();
        for (int e = 0; e < 4000; e++) begin
            if (seg == 0) begin
                v   = ~v;
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20)) : int'($urandom_range(1, 5));
            end
            seg--;
            key_in = v;
            if ($urandom_range(0, 599) == 0) begin
                n_rst = 1'b0;
                model_clear();
            end else begin
                n_rst = 1'b1;
            end
            step();
            checks++;
            if (dout_h !== m_pulse || level_h !== m_level || dout_l !== m_pulse || level_l !== m_level) begin
                errors++;
                $display("FAIL random e=%0d dout=%b/%b level=%b/%b expected dout=%b level=%b", e, dout_h, dout_l, level_h, level_l, m_pulse, m_level);
            end
            @(negedge clk);
        end
        n_rst = 1'b1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_reset_mid_check();
        test_active_low();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_pulse.md
KEY_PULSE -- requirements
Module: key_pulse

Interface
REQ-001 Parameter N, default 20, debounce counter width; stable time = 2^N clk cycles (2^20 * 20 ns, about 21 ms).
REQ-002 Parameter KEY_ACT, default 1'b1, active level of raw key_in; 1'b0 for pull-up buttons.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 key_in  input  1  raw asynchronous push-button level, bouncing.
REQ-006 dout  output  1  registered single-cycle pulse per confirmed press; feeds the downstream pulse-stretch (din) input.
REQ-007 level  output  1  registered debounced key level, 1 = pressed.

Function
REQ-008 key_in SHALL pass through a two-flop synchronizer (sync1, sync2), XORed with ~KEY_ACT so that sync2 = 1 means active.
REQ-009 FSM SHALL have four states: S_IDLE, S_PCHK (press check), S_HELD, S_RCHK (release check).
REQ-010 Counter cnt SHALL be N bits, count down, and wrap-free: it is loaded with all-ones on entering a check state and decremented by 1 each cycle in that state.
REQ-011 S_IDLE: sync2 = 1 SHALL go to S_PCHK and load cnt; otherwise stay.
REQ-012 S_PCHK: sync2 = 0 SHALL return to S_IDLE (bounce rejected, no pulse); else cnt = 0 SHALL go to S_HELD; else decrement.
REQ-013 S_HELD: sync2 = 0 SHALL go to S_RCHK and load cnt; otherwise stay.
REQ-014 S_RCHK: sync2 = 1 SHALL return to S_HELD with no pulse; else cnt = 0 SHALL go to S_IDLE; else decrement.
REQ-015 If sync2 deasserts in the same cycle cnt = 0 in S_PCHK, the sync2 check SHALL win (go to S_IDLE); the same priority applies in S_RCHK (sync2 = 1 wins, go to S_HELD).
REQ-016 dout SHALL be 1 for exactly one cycle, the first cycle in S_HELD entered from S_PCHK; never on S_RCHK to S_HELD.
REQ-017 Latency: if sync1 first samples the active level at edge k and it stays stable, state = S_PCHK after edge k+2, dout = 1 from edge k+2+2^N to edge k+3+2^N.
REQ-018 level SHALL be 1 in S_HELD and S_RCHK, and 0 in S_IDLE and S_PCHK, registered alongside state.
REQ-019 Holding the key indefinitely SHALL produce no further dout pulses (no auto-repeat).
REQ-020 Release SHALL need 2^N stable inactive cycles before level falls; a new press pulse SHALL require passing S_IDLE again.

Reset
REQ-021 n_rst low SHALL immediately force state = S_IDLE, cnt = 0, sync1 = sync2 = 0, dout = 0, level = 0, including mid-check or mid-pulse.
REQ-022 After n_rst rises, with the key already held, the block SHALL debounce it as a fresh press (one pulse after REQ-017 latency).

Verification (bench N = 2, KEY_ACT = 1)
REQ-023 Clean press: key_in goes 0 to 1 at edge 0 and is held -> dout = 1 during exactly edge 6 to edge 7, level = 1 from edge 6, no further pulses over 50 cycles.
REQ-024 Bounce: key_in is 1 for 3 cycles, 0 for 1 cycle, then 1 held -> no pulse for the short burst; exactly one pulse, 4 cycles after S_PCHK is re-entered.
REQ-025 Release glitch: in S_HELD, key_in drops for 2 cycles then returns -> level stays 1, dout stays 0; a full 4+ cycle release -> level = 0 after 2 + 4 + 1 edges.
REQ-026 Reset mid-check: assert n_rst during S_PCHK with cnt = 2 -> outputs are 0 asynchronously; release with key held -> one pulse at the full REQ-017 latency.
REQ-027 KEY_ACT = 0: key_in goes 1 to 0 and is held -> one pulse at edge 6, identical timing to REQ-023.
REQ-028 Boundary: key_in falls in the cycle where cnt = 0 in S_PCHK -> S_IDLE, no pulse.
